fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Parametrised sequencer for a time-multiplexed FIR/convolution datapath built around one external MAC, with an input data RAM, a coefficient ROM and an output RAM.
For each output sample n in 0..DEPTH-1 it does the following:
- Walks taps k = 0..TAPS-1.
- Drives the data address (n-k), the coefficient index (k) and the accumulator controls.
- Scales the accumulator result and writes it back.
Adds start/clear/done handshaking, zero-padding at the sequence head and optional output saturation.

Parameters:
TAPS, 8, number of coefficients per output sample (>=1, <=2**CIDX_W)
DEPTH, 64, number of samples per run (>=1, <=2**ADDR_W)
ADDR_W, 6, data/output RAM address width
CIDX_W, 4, coefficient index width
ACC_W, 36, accumulator width (signed two's complement)
DOUT_W, 16, output sample width
SHIFT, 0, arithmetic right shift applied to acc before output (0..ACC_W-DOUT_W)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a run; sampled only in IDLE
clear  in  1  synchronous abort/clear, any state
acc  in  ACC_W  accumulator value from the external MAC (registered there, updates on the edge after acc_en)
rd_addr  out  ADDR_W  data RAM read address (n-k)
coef_idx  out  CIDX_W  coefficient ROM index (k)
data_zero  out  1  datapath must use 0 instead of RAM data (k>n)
acc_en  out  1  MAC accumulate enable
acc_clr  out  1  with acc_en: load the product instead of adding it
wr_addr  out  ADDR_W  output RAM write address (n)
mem_we  out  1  output RAM write enable
dout  out  DOUT_W  scaled output sample (registered)
ovf  out  1  sticky overflow flag
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of a run

Behaviour:
- Reset is asynchronous and active-low on rst; the clock is clk.
- Reset values: all outputs are 0 and the FSM is in IDLE. The internal counters are n = 0 and k = 0.
- FSM states: IDLE, MAC, SAT, WR.
- IDLE:
  - busy=0.
  - start=1 -> MAC with n=0, k=0.
- MAC:
  - busy=1, acc_en=1, coef_idx=k.
  - acc_clr=1 only when k=0.
  - If k<=n: rd_addr = n-k, taken modulo 2**ADDR_W. If k>n: data_zero=1 and rd_addr=0.
  - Lasts TAPS cycles, k=0..TAPS-1. After k=TAPS-1 -> SAT and k resets to 0.
- SAT:
  - acc_en=0. acc now holds the sum for sample n.
  - dout is registered at the end of this cycle from the scaled acc (see Optional Feature).
  - -> WR.
- WR:
  - mem_we=1, wr_addr=n. dout is valid this cycle.
  - If n=DEPTH-1 -> IDLE, n=0, and done=1 in the following cycle.
  - Otherwise n++ and -> MAC.
- Cost per sample is TAPS+2 cycles, so a run takes DEPTH*(TAPS+2) cycles.
  - busy rises the cycle after start is sampled and falls together with the done pulse.
- start while busy=1 is ignored.
- clear:
  - Next state is IDLE. n, k and dout return to 0, and ovf is cleared.
  - Writes and done are suppressed.
  - If clear and start are high in the same cycle, clear wins.
- Asynchronous reset mid-run aborts the run immediately with the reset values above; no done.
- ovf: sticky. It is set in SAT when saturation clamps, and cleared only by clear or rst.
- Control outputs are decoded from registered state; dout, ovf and done are registers.

Optional Feature:
Macro FIR_SAT_EN.
- Defined:
  - Compute s = acc >>> SHIFT (arithmetic shift).
  - If s > 2**(DOUT_W-1)-1, then dout = 2**(DOUT_W-1)-1 and ovf is set.
  - If s < -2**(DOUT_W-1), then dout = -2**(DOUT_W-1) and ovf is set.
  - Otherwise dout = s[DOUT_W-1:0].
- Undefined:
  - dout = (acc >>> SHIFT)[DOUT_W-1:0], plain truncation.
  - ovf is tied to 0.

Test Plan:
- Reset: assert rst low mid-MAC -> all outputs 0 immediately. After release, start -> busy=1 next cycle, and the first MAC cycle has k=0, acc_clr=1, rd_addr=0.
- Defaults, sample n=2 -> coef_idx 0..7 with rd_addr 2,1,0. For k=3..7, data_zero=1 and rd_addr=0. SAT follows, then WR with wr_addr=2.
- Impulse: x[0]=1, others 0; h={1..8} via the bench MAC model -> output RAM[0..7]=1..8 and RAM[8..63]=0. done pulses exactly 640 cycles after busy rises; busy=0 in the same cycle.
- Saturation: acc=36'h0_0001_0000, SHIFT=0.
  - With FIR_SAT_EN: dout=16'h7FFF, ovf=1.
  - With acc=-36'h0_0001_0000: dout=16'h8000.
  - Without FIR_SAT_EN: dout=16'h0000 and ovf=0.
- Abort: clear asserted in MAC of n=5 -> IDLE next cycle with n=0. No further mem_we, no done, ovf=0. A new start runs the full sequence from n=0.
- Handshake: start re-pulsed at n=10 -> ignored, run completes normally. start and clear high together in IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/fir_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the FIR sequencer and its
// MAC / data RAM / coefficient ROM / output RAM environment.
interface fir_seq_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int CIDX_W = 4,
  parameter int ACC_W  = 36,
  parameter int DOUT_W = 16
);
  logic              start;
  logic              clear;
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] rd_addr;
  logic [CIDX_W-1:0] coef_idx;
  logic              data_zero;
  logic              acc_en;
  logic              acc_clr;
  logic [ADDR_W-1:0] wr_addr;
  logic              mem_we;
  logic [DOUT_W-1:0] dout;
  logic              ovf;
  logic              busy;
  logic              done;

  // Sequencer side.
  modport master (
    input  start, clear, acc,
    output rd_addr, coef_idx, data_zero, acc_en, acc_clr,
           wr_addr, mem_we, dout, ovf, busy, done
  );

  // Environment side (MAC, memories, host).
  modport slave (
    output start, clear, acc,
    input  rd_addr, coef_idx, data_zero, acc_en, acc_clr,
           wr_addr, mem_we, dout, ovf, busy, done
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Tap/sample sequencer for a time-multiplexed FIR built around one external MAC.
// Output saturation (with sticky ovf) is enabled by defining FIR_SAT_EN.
module fir_seq_ctrl #(
  parameter int TAPS   = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CIDX_W = 4,
  parameter int ACC_W  = 36,
  parameter int DOUT_W = 16,
  parameter int SHIFT  = 0
) (
  input logic            clk,
  input logic            rst,
  fir_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SAT  = 2'd2,
    S_WR   = 2'd3
  } state_e;

  localparam int CMP_W = (ADDR_W > CIDX_W) ? ADDR_W : CIDX_W;

  localparam logic [CIDX_W-1:0] K_ZERO = {CIDX_W{1'b0}};
  localparam logic [CIDX_W-1:0] K_ONE  = CIDX_W'(1'b1);
  localparam logic [CIDX_W-1:0] K_LAST = CIDX_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] N_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] N_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DOUT_W-1:0] D_ZERO = {DOUT_W{1'b0}};

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
`endif

  // Returns {clamped, sample}: the accumulator scaled down to the output width.
  function automatic logic [DOUT_W:0] scale_acc(input logic [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] s;
    s = $signed(a) >>> SHIFT;
    if (s > SAT_MAX) begin
      scale_acc = {1'b1, 1'b0, {(DOUT_W-1){1'b1}}};
    end else if (s < SAT_MIN) begin
      scale_acc = {1'b1, 1'b1, {(DOUT_W-1){1'b0}}};
    end else begin
      scale_acc = {1'b0, s[DOUT_W-1:0]};
    end
`else
    scale_acc = {1'b0, DOUT_W'($signed(a) >>> SHIFT)};
`endif
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [CIDX_W-1:0] k_q, k_d;

  logic              busy_q, busy_d;
  logic              acc_en_q, acc_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic [CIDX_W-1:0] coef_idx_q, coef_idx_d;
  logic              data_zero_q, data_zero_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [DOUT_W:0]   scaled;

  // Next state and sample/tap counters; clear overrides everything.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      n_d     = N_ZERO;
      k_d     = K_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_MAC;
            n_d     = N_ZERO;
            k_d     = K_ZERO;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MAC: begin
          if (k_q == K_LAST) begin
            state_d = S_SAT;
            k_d     = K_ZERO;
          end else begin
            k_d = k_q + K_ONE;
          end
        end
        S_SAT: begin
          state_d = S_WR;
        end
        S_WR: begin
          if (n_q == N_LAST) begin
            state_d = S_IDLE;
            n_d     = N_ZERO;
          end else begin
            state_d = S_MAC;
            n_d     = n_q + N_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          n_d     = N_ZERO;
          k_d     = K_ZERO;
        end
      endcase
    end
  end

  // Control outputs are decoded from the next state so the registered copies
  // line up exactly with the state they describe.
  always_comb begin
    scaled      = scale_acc(bus.acc);
    busy_d      = (state_d != S_IDLE);
    acc_en_d    = (state_d == S_MAC);
    acc_clr_d   = 1'b0;
    coef_idx_d  = K_ZERO;
    data_zero_d = 1'b0;
    rd_addr_d   = N_ZERO;
    mem_we_d    = (state_d == S_WR);
    wr_addr_d   = N_ZERO;
    if (state_d == S_MAC) begin
      acc_clr_d  = (k_d == K_ZERO);
      coef_idx_d = k_d;
      if (CMP_W'(k_d) > CMP_W'(n_d)) begin
        data_zero_d = 1'b1;
      end else begin
        rd_addr_d = n_d - ADDR_W'(k_d);
      end
    end else begin
      acc_clr_d = 1'b0;
    end
    if (state_d == S_WR) begin
      wr_addr_d = n_d;
    end else begin
      wr_addr_d = N_ZERO;
    end
    done_d = !bus.clear && (state_q == S_WR) && (n_q == N_LAST);
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (bus.clear) begin
      dout_d = D_ZERO;
      ovf_d  = 1'b0;
    end else if (state_q == S_SAT) begin
      dout_d = scaled[DOUT_W-1:0];
      ovf_d  = ovf_q | scaled[DOUT_W];
    end else begin
      dout_d = dout_q;
    end
  end

  // State, counters and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_q         <= N_ZERO;
      k_q         <= K_ZERO;
      busy_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      coef_idx_q  <= K_ZERO;
      data_zero_q <= 1'b0;
      rd_addr_q   <= N_ZERO;
      mem_we_q    <= 1'b0;
      wr_addr_q   <= N_ZERO;
      dout_q      <= D_ZERO;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      acc_en_q    <= acc_en_d;
      acc_clr_q   <= acc_clr_d;
      coef_idx_q  <= coef_idx_d;
      data_zero_q <= data_zero_d;
      rd_addr_q   <= rd_addr_d;
      mem_we_q    <= mem_we_d;
      wr_addr_q   <= wr_addr_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.coef_idx  = coef_idx_q;
  assign bus.data_zero = data_zero_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: MAC and output-RAM models around the DUT, with a
// convolution reference model for the written samples.
`timescale 1ns/1ps
module tb_fir_seq_ctrl;
  localparam int TAPS   = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int CIDX_W = 4;
  localparam int ACC_W  = 36;
  localparam int DOUT_W = 16;
  localparam int SHIFT  = 0;
  localparam int PER    = TAPS + 2;
  localparam int RUN    = DEPTH * PER;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.ADDR_W(ADDR_W), .CIDX_W(CIDX_W), .ACC_W(ACC_W), .DOUT_W(DOUT_W)) bus ();

  fir_seq_ctrl #(
    .TAPS(TAPS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CIDX_W(CIDX_W),
    .ACC_W(ACC_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int xs [DEPTH];
  int hs [2**CIDX_W];
  logic [DOUT_W-1:0] yexp [DEPTH];
  logic              oexp [DEPTH];
  logic              ovf_exp;
  logic [DOUT_W-1:0] ram [DEPTH];
  logic              ram_wipe;
  logic              force_en;
  logic [ACC_W-1:0]  acc_force;
  logic [ACC_W-1:0]  mac_acc;
  logic [ACC_W-1:0]  prod;

  // External MAC: product of RAM data (or zero) and coefficient.
  assign prod = bus.data_zero ? {ACC_W{1'b0}}
              : ACC_W'(longint'(xs[bus.rd_addr]) * longint'(hs[bus.coef_idx]));

  always @(posedge clk or negedge rst) begin
    if (!rst) mac_acc <= {ACC_W{1'b0}};
    else if (bus.acc_en) mac_acc <= bus.acc_clr ? prod : mac_acc + prod;
  end

  assign bus.acc = force_en ? acc_force : mac_acc;

  always @(posedge clk) begin
    if (ram_wipe) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 16'hDEAD;
    end else if (bus.mem_we) begin
      ram[bus.wr_addr] <= bus.dout;
    end
  end

  function automatic logic [DOUT_W:0] ref_out(input longint s);
    longint v;
    v = s >>> SHIFT;
`ifdef FIR_SAT_EN
    if (v > 64'sd32767) return {1'b1, 16'h7FFF};
    if (v < -64'sd32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, v[DOUT_W-1:0]};
  endfunction

  task automatic build_model();
    longint s;
    for (int n = 0; n < DEPTH; n++) begin
      s = 0;
      for (int k = 0; k < TAPS; k++)
        if (k <= n) s += longint'(xs[n-k]) * longint'(hs[k]);
      {oexp[n], yexp[n]} = ref_out(s);
    end
  endtask

  task automatic random_data();
    for (int i = 0; i < DEPTH; i++) xs[i] = int'($urandom_range(0, 511)) - 256;
    for (int i = 0; i < 2**CIDX_W; i++) hs[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] all_out();
    return {bus.busy, bus.acc_en, bus.acc_clr, bus.coef_idx, bus.data_zero, bus.rd_addr,
            bus.mem_we, bus.wr_addr, bus.done, bus.ovf, bus.dout};
  endfunction

  // Full run: per-cycle schedule check, done timing, then output RAM contents.
  task automatic run_and_check(input string name, input int repulse);
    int n, p;
    logic mac, wr;
    logic [21:0] obs, exp;
    build_model();
    ram_wipe = 1'b1;
    tick();
    ram_wipe = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < RUN; c++) begin
      n = c / PER;
      p = c % PER;
      mac = (p < TAPS);
      wr  = (p == PER - 1);
      exp = {1'b1, mac, mac && (p == 0), mac ? CIDX_W'(p) : 4'd0, mac && (p > n),
             (mac && (p <= n)) ? ADDR_W'(n - p) : 6'd0, wr, wr ? ADDR_W'(n) : 6'd0, 1'b0};
      obs = {bus.busy, bus.acc_en, mac ? bus.acc_clr : 1'b0, mac ? bus.coef_idx : 4'd0,
             mac ? bus.data_zero : 1'b0, mac ? bus.rd_addr : 6'd0, bus.mem_we,
             wr ? bus.wr_addr : 6'd0, bus.done};
      chk({name, " ctl"}, 64'(obs), 64'(exp));
      if (wr) begin
        ovf_exp = ovf_exp | oexp[n];
        chk({name, " dout"}, 64'(bus.dout), 64'(yexp[n]));
        chk({name, " ovf"}, 64'(bus.ovf), 64'(ovf_exp));
      end
      bus.start = (c == repulse);
      tick();
    end
    bus.start = 1'b0;
    chk({name, " done_busy"}, 64'({bus.done, bus.busy}), 64'(2'b10));
    tick();
    chk({name, " done_pulse_end"}, 64'({bus.done, bus.busy}), 64'(2'b00));
    for (int i = 0; i < DEPTH; i++)
      chk({name, " ram"}, 64'(ram[i]), 64'(yexp[i]));
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    ram_wipe = 1'b0;
    force_en = 1'b0;
    acc_force = {ACC_W{1'b0}};
    ovf_exp = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 64'(all_out()), 64'd0);
    rst = 1'b1;
    tick();

    // Impulse response: output equals the coefficient set.
    for (int i = 0; i < DEPTH; i++) xs[i] = (i == 0) ? 1 : 0;
    for (int i = 0; i < 2**CIDX_W; i++) hs[i] = i + 1;
    run_and_check("impulse", -1);
    for (int i = 0; i < DEPTH; i++)
      chk("impulse_const", 64'(ram[i]), (i < TAPS) ? 64'(i + 1) : 64'd0);

    // Asynchronous reset in the middle of the MAC phase.
    random_data();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_coef", 64'({bus.acc_en, bus.coef_idx}), 64'({1'b1, 4'd3}));
    #2 rst = 1'b0;
    #1 chk("async_reset", 64'(all_out()), 64'd0);
    ovf_exp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_and_check("after_reset", -1);

    // Start re-pulsed while busy is ignored.
    random_data();
    run_and_check("repulse", 10 * PER + 2);

    // start and clear together in IDLE: clear wins.
    bus.start = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    ovf_exp = 1'b0;
    chk("start_clear_idle", 64'(all_out()), 64'd0);
    tick();
    chk("start_clear_idle2", 64'({bus.busy, bus.acc_en}), 64'd0);

    // Abort with clear in the MAC phase of sample 5.
    random_data();
    build_model();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 5 * PER + 3; c++) tick();
    chk("pre_abort", 64'({bus.acc_en, bus.coef_idx, bus.rd_addr}), 64'({1'b1, 4'd3, 6'd2}));
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    ovf_exp = 1'b0;
    chk("abort_idle", 64'(all_out()), 64'd0);
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("abort_quiet", 64'({bus.busy, bus.mem_we, bus.done, bus.ovf}), 64'd0);
    end
    random_data();
    run_and_check("after_abort", -1);

    // Saturation / truncation with a forced accumulator value.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    ovf_exp = 1'b0;
    force_en = 1'b1;
    acc_force = 36'h0_0001_0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < TAPS + 1; c++) tick();
    chk("sat_pos_we", 64'(bus.mem_we), 64'd1);
`ifdef FIR_SAT_EN
    chk("sat_pos", 64'({bus.ovf, bus.dout}), 64'({1'b1, 16'h7FFF}));
`else
    chk("sat_pos", 64'({bus.ovf, bus.dout}), 64'({1'b0, 16'h0000}));
`endif
    acc_force = 36'hF_FFFF_0000;
    for (int c = 0; c < PER; c++) tick();
`ifdef FIR_SAT_EN
    chk("sat_neg", 64'({bus.ovf, bus.dout}), 64'({1'b1, 16'h8000}));
`else
    chk("sat_neg", 64'({bus.ovf, bus.dout}), 64'({1'b0, 16'h0000}));
`endif
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    force_en = 1'b0;
    chk("sat_cleared", 64'(all_out()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
